// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO.
// Default depth and pointer-width function.
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;

  // Pointer width, never below 1 bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: sync write port, async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [clog2_min1(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [clog2_min1(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, flags, read mode.
// Ports: clk, rst, flush, wr_en/din, rd_en/dout, status flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [clog2_min1(DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_err
    $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_af_err
    $error("sync_fifo: AFULL_THRESH out of range 1..DEPTH");
  end
  if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_ae_err
    $error("sync_fifo: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] dout_q;
  logic             wr_acc;
  logic             rd_acc;

  // Flags depend on the count register only.
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);
  assign count        = cnt;

  // Flush and reset swallow requests outright.
  assign wr_acc = wr_en & ~full  & ~flush & ~rst;
  assign rd_acc = rd_en & ~empty & ~flush & ~rst;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (tail),
    .wdata (din),
    .raddr (head),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dout_q    <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) tail <= tail + 1'b1;
      if (rd_acc) head <= head + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
      if (rd_acc) dout_q <= rdata;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = rdata;
  end else begin : g_reg
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: registered and FWFT instances, one stimulus.
// Hand-derived vector table plus random traffic against a queue model.
module tb_sync_fifo;

  localparam int W = 8;
  localparam int D = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] din = '0;

  logic         full0, afull0, empty0, aempty0, ov0, un0;
  logic [W-1:0] dout0;
  logic [2:0]   count0;
  logic         full1, afull1, empty1, aempty1, ov1, un1;
  logic [W-1:0] dout1;
  logic [2:0]   count1;

  always #5 clk = ~clk;

  sync_fifo #(
    .WIDTH(W), .DEPTH(D), .FWFT(0),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .din(din),
    .full(full0), .almost_full(afull0),
    .rd_en(rd_en), .dout(dout0),
    .empty(empty0), .almost_empty(aempty0),
    .count(count0),
    .overflow(ov0), .underflow(un0)
  );

  sync_fifo #(
    .WIDTH(W), .DEPTH(D), .FWFT(1),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .din(din),
    .full(full1), .almost_full(afull1),
    .rd_en(rd_en), .dout(dout1),
    .empty(empty1), .almost_empty(aempty1),
    .count(count1),
    .overflow(ov1), .underflow(un1)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: contents queue, last popped word, pulses.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  logic         m_ov = 1'b0;
  logic         m_un = 1'b0;

  task automatic model(input logic r, f, w, rd,
                       input logic [W-1:0] d);
    bit wa, ra;
    if (r) begin
      q.delete();
      m_dout = '0;
      m_ov = 0;
      m_un = 0;
    end else if (f) begin
      q.delete();
      m_ov = 0;
      m_un = 0;
    end else begin
      wa = w && (q.size() < D);
      ra = rd && (q.size() > 0);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      m_ov = w && !wa;
      m_un = rd && !ra;
    end
  endtask

  task automatic step(input logic r, f, w, rd,
                      input logic [W-1:0] d);
    int n;
    rst = r; flush = f; wr_en = w; rd_en = rd; din = d;
    @(posedge clk);
    model(r, f, w, rd, d);
    #1;
    n = q.size();
    chk("count0", 32'(count0), 32'(n));
    chk("count1", 32'(count1), 32'(n));
    chk("empty", 32'(empty0), 32'(n == 0));
    chk("full", 32'(full0), 32'(n == D));
    chk("almost_full", 32'(afull0), 32'(n >= AF));
    chk("almost_empty", 32'(aempty0), 32'(n <= AE));
    chk("overflow", 32'(ov0), 32'(m_ov));
    chk("underflow", 32'(un0), 32'(m_un));
    chk("ovf_fwft", 32'(ov1), 32'(m_ov));
    chk("unf_fwft", 32'(un1), 32'(m_un));
    chk("dout_reg", 32'(dout0), 32'(m_dout));
    if (n > 0) chk("dout_fwft", 32'(dout1), 32'(q[0]));
  endtask

  typedef struct {
    logic         r, f, w, rd;
    logic [W-1:0] d;
    int           cnt;
    logic         ov, un;
    logic [W-1:0] dq;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, f, w, rd,
                              logic [W-1:0] d, int c,
                              logic ov, un,
                              logic [W-1:0] dq);
    vec_t v;
    v.r = r; v.f = f; v.w = w; v.rd = rd; v.d = d;
    v.cnt = c; v.ov = ov; v.un = un; v.dq = dq;
    tbl.push_back(v);
  endfunction

  initial begin
    // reset, fill, overflow, drain, underflow
    add(1,0,0,0,8'h00, 0,0,0,8'h00);
    add(0,0,1,0,8'h11, 1,0,0,8'h00);
    add(0,0,1,0,8'h22, 2,0,0,8'h00);
    add(0,0,1,0,8'h33, 3,0,0,8'h00);
    add(0,0,1,0,8'h44, 4,0,0,8'h00);
    add(0,0,1,0,8'h55, 4,1,0,8'h00);
    add(0,0,0,0,8'h00, 4,0,0,8'h00);
    add(0,0,0,1,8'h00, 3,0,0,8'h11);
    add(0,0,0,1,8'h00, 2,0,0,8'h22);
    add(0,0,0,1,8'h00, 1,0,0,8'h33);
    add(0,0,0,1,8'h00, 0,0,0,8'h44);
    add(0,0,0,1,8'h00, 0,0,1,8'h44);
    add(0,0,0,0,8'h00, 0,0,0,8'h44);
    // single word visible on the FWFT port without a read
    add(0,0,1,0,8'hA5, 1,0,0,8'h44);
    add(0,0,0,1,8'h00, 0,0,0,8'hA5);
    add(0,0,0,1,8'h00, 0,0,1,8'hA5);
    // steady state at count 2 across pointer wraps
    add(0,0,1,0,8'h00, 1,0,0,8'hA5);
    add(0,0,1,0,8'h01, 2,0,0,8'hA5);
    for (int k = 0; k < 10; k++)
      add(0,0,1,1,8'(k + 2), 2,0,0,8'(k));
    add(0,0,0,1,8'h00, 1,0,0,8'h0A);
    add(0,0,0,1,8'h00, 0,0,0,8'h0B);
    // both requests while full, then while empty
    add(0,0,1,0,8'hC1, 1,0,0,8'h0B);
    add(0,0,1,0,8'hC2, 2,0,0,8'h0B);
    add(0,0,1,0,8'hC3, 3,0,0,8'h0B);
    add(0,0,1,0,8'hC4, 4,0,0,8'h0B);
    add(0,0,1,1,8'h99, 3,1,0,8'hC1);
    add(0,0,0,1,8'h00, 2,0,0,8'hC2);
    add(0,0,0,1,8'h00, 1,0,0,8'hC3);
    add(0,0,0,1,8'h00, 0,0,0,8'hC4);
    add(0,0,1,1,8'h77, 1,0,1,8'hC4);
    add(0,0,0,1,8'h00, 0,0,0,8'h77);
    // flush with a concurrent write
    add(0,0,1,0,8'h01, 1,0,0,8'h77);
    add(0,0,1,0,8'h02, 2,0,0,8'h77);
    add(0,0,1,0,8'h03, 3,0,0,8'h77);
    add(0,1,1,0,8'hEE, 0,0,0,8'h77);
    add(0,0,1,0,8'h5A, 1,0,0,8'h77);
    add(0,0,0,1,8'h00, 0,0,0,8'h5A);
    // reset in mid-stream
    add(0,0,1,0,8'h10, 1,0,0,8'h5A);
    add(0,0,1,0,8'h20, 2,0,0,8'h5A);
    add(1,0,1,0,8'h30, 0,0,0,8'h00);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].f, tbl[i].w,
           tbl[i].rd, tbl[i].d);
      chk($sformatf("vec%0d_count", i),
          32'(count0), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_ovf", i),
          32'(ov0), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_unf", i),
          32'(un0), 32'(tbl[i].un));
      chk($sformatf("vec%0d_dout", i),
          32'(dout0), 32'(tbl[i].dq));
    end

    // random traffic: write-biased, then read-biased
    for (int i = 0; i < 600; i++) begin
      int wp;
      logic r, f, w, rd;
      wp = (i % 200 < 100) ? 70 : 30;
      r  = ($urandom_range(99) < 2);
      f  = ($urandom_range(99) < 3);
      w  = ($urandom_range(99) < wp);
      rd = ($urandom_range(99) < 100 - wp);
      step(r, f, w, rd, 8'($urandom));
    end

    rst = 0; flush = 0; wr_en = 0; rd_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
